// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared types for the rolly FIFO replay controller: receiver response codes and controller states.
package bsg_fifo_rolly_pkg;

    typedef enum logic [1:0] {
        ACK_ONE = 2'd0,
        ACK_ALL = 2'd1,
        NACK    = 2'd2
    } resp_type_e;

    typedef enum logic {
        RUN   = 1'b0,
        ERROR = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_fifo_rolly_replay_ctrl_if.sv
// Outbound link channel of the replay controller: sequence-tagged beats with valid-then-ready handshake.
interface bsg_fifo_rolly_replay_ctrl_if #(
    parameter int width_p     = 8,
    parameter int seq_width_p = 4
);

    logic [width_p-1:0]     data;
    logic [seq_width_p-1:0] seq;
    logic                   v;
    logic                   ready;

    modport master (output data, output seq, output v, input ready);
    modport slave  (input data, input seq, input v, output ready);

endinterface

// File: rtl/bsg_rolly_timeout_ctr.sv
// Response timeout counter: pulses expired_o when the count reaches timeout_p-1, then wraps to zero.
module bsg_rolly_timeout_ctr #(
    parameter int timeout_p = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int cnt_width_lp = $clog2(timeout_p);
    localparam logic [cnt_width_lp-1:0] last_lp = cnt_width_lp'(timeout_p - 1);

    logic [cnt_width_lp-1:0] count;

    assign expired_o = (count == last_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i | clear_i | expired_o)
            count <= '0;
        else if (en_i)
            count <= count + cnt_width_lp'(1);
    end

endmodule

// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Go-back-N retransmit controller on the read side of a rolly FIFO: tags beats, retires them on acks,
// rewinds the FIFO on nack or timeout, and latches an error once the retry budget is exhausted.
module bsg_fifo_rolly_replay_ctrl
    import bsg_fifo_rolly_pkg::*;
#(
    parameter int width_p       = 8,
    parameter int lg_size_p     = 3,
    parameter int window_p      = 4,
    parameter int seq_width_p   = 4,
    parameter int timeout_p     = 64,
    parameter int max_retries_p = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic [width_p-1:0]     fifo_data_i,
    input  logic                   fifo_v_i,
    output logic                   fifo_yumi_o,
    output logic                   fifo_incr_v_o,
    output logic                   fifo_rollback_v_o,
    output logic                   fifo_ack_v_o,

    bsg_fifo_rolly_replay_ctrl_if.master link,

    input  logic                   resp_v_i,
    input  logic [1:0]             resp_type_i,

    output logic [lg_size_p:0]     outstanding_o,
    output logic                   error_o
);

    localparam int ctr_width_lp   = lg_size_p + 1;
    localparam int retry_width_lp = (max_retries_p < 1) ? 1 : $clog2(max_retries_p + 1);
    localparam logic [ctr_width_lp-1:0]   window_lp    = ctr_width_lp'(window_p);
    localparam logic [retry_width_lp-1:0] retry_max_lp = retry_width_lp'(max_retries_p);

    state_e                    state;
    logic [ctr_width_lp-1:0]   outstanding;
    logic [seq_width_p-1:0]    seq_r;
    logic [seq_width_p-1:0]    base_seq_r;
    logic [retry_width_lp-1:0] retries;
    logic                      error_r;

    logic run, busy, expired;
    logic ack_one, ack_all, nack;
    logic rollback, ack, incr, send, yumi;

    assign run  = (state == RUN) & ~reset_i;
    assign busy = (outstanding != '0);

    assign ack_one = resp_v_i & (resp_type_i == ACK_ONE);
    assign ack_all = resp_v_i & (resp_type_i == ACK_ALL);
    assign nack    = resp_v_i & (resp_type_i == NACK);

    // One FIFO op per cycle: rollback beats ack beats incr; a cycle carrying rollback or ack sends nothing.
    assign rollback = run & (nack | (expired & busy));
    assign ack      = run & ~rollback & ack_all;
    assign incr     = run & ~rollback & ~ack & ack_one & busy;
    assign send     = run & fifo_v_i & (outstanding < window_lp) & ~(rollback | ack);
    assign yumi     = send & link.ready;

    assign link.v    = send;
    assign link.data = fifo_data_i;
    assign link.seq  = seq_r;

    assign fifo_yumi_o       = yumi;
    assign fifo_incr_v_o     = incr;
    assign fifo_rollback_v_o = rollback;
    assign fifo_ack_v_o      = ack;

    assign outstanding_o = reset_i ? '0 : outstanding;
    assign error_o       = error_r & ~reset_i;

    bsg_rolly_timeout_ctr #(
        .timeout_p (timeout_p)
    ) timeout_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (resp_v_i | ~busy | rollback),
        .en_i      (busy & ~resp_v_i),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= RUN;
            outstanding <= '0;
            seq_r       <= '0;
            base_seq_r  <= '0;
            retries     <= '0;
            error_r     <= 1'b0;
        end else if (state == RUN) begin
            if (rollback) begin
                seq_r       <= base_seq_r;
                outstanding <= '0;
                if (retries == retry_max_lp) begin
                    state   <= ERROR;
                    error_r <= 1'b1;
                end else begin
                    retries <= retries + retry_width_lp'(1);
                end
            end else if (ack) begin
                base_seq_r  <= seq_r;
                outstanding <= '0;
                if (busy)
                    retries <= '0;
            end else begin
                // A retire and a send in the same cycle leave the window occupancy unchanged.
                if (yumi)
                    seq_r <= seq_r + seq_width_p'(1);
                if (incr) begin
                    base_seq_r <= base_seq_r + seq_width_p'(1);
                    retries    <= '0;
                end
                if (yumi & ~incr)
                    outstanding <= outstanding + ctr_width_lp'(1);
                else if (incr & ~yumi)
                    outstanding <= outstanding - ctr_width_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert ((outstanding <= window_lp) &&
                    ((seq_r - base_seq_r) == seq_width_p'(outstanding)));
    end

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
// Directed and randomized bench for the rolly FIFO replay controller against a queue-based reference model.
module tb_bsg_fifo_rolly_replay_ctrl;
    import bsg_fifo_rolly_pkg::*;

    localparam int width_lp       = 8;
    localparam int lg_size_lp     = 3;
    localparam int window_lp      = 4;
    localparam int seq_width_lp   = 4;
    localparam int timeout_lp     = 8;
    localparam int max_retries_lp = 3;

    logic                  clk = 1'b0;
    logic                  reset_i = 1'b1;
    logic [width_lp-1:0]   fifo_data;
    logic                  fifo_v;
    logic                  yumi, incr_v, rollback_v, ack_v;
    logic                  resp_v;
    logic [1:0]            resp_type;
    logic [lg_size_lp:0]   outstanding;
    logic                  error;

    bsg_fifo_rolly_replay_ctrl_if #(.width_p(width_lp), .seq_width_p(seq_width_lp)) link ();

    bsg_fifo_rolly_replay_ctrl #(
        .width_p       (width_lp),
        .lg_size_p     (lg_size_lp),
        .window_p      (window_lp),
        .seq_width_p   (seq_width_lp),
        .timeout_p     (timeout_lp),
        .max_retries_p (max_retries_lp)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .fifo_data_i       (fifo_data),
        .fifo_v_i          (fifo_v),
        .fifo_yumi_o       (yumi),
        .fifo_incr_v_o     (incr_v),
        .fifo_rollback_v_o (rollback_v),
        .fifo_ack_v_o      (ack_v),
        .link              (link),
        .resp_v_i          (resp_v),
        .resp_type_i       (resp_type),
        .outstanding_o     (outstanding),
        .error_o           (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference controller: in-flight tags in send order, next tag, retry budget, idle-cycle count.
    int q[$];
    int next_seq, retries, timer;
    bit err;

    // Environment rolly FIFO: beats stored by index with read pointer and checkpoint.
    logic [width_lp-1:0] mem [0:1023];
    int wr, rd, ckpt;

    bit seen_v, seen_yumi, seen_rb, seen_incr, seen_err;
    logic [width_lp-1:0]     seen_data;
    logic [seq_width_lp-1:0] seen_seq;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr] = width_lp'($urandom);
            wr++;
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_seq = 0;
        retries  = 0;
        timer    = 0;
        err      = 1'b0;
        wr = 0; rd = 0; ckpt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i   = 1'b1;
        fifo_v    = 1'b1;
        fifo_data = width_lp'($urandom);
        link.ready = 1'b1;
        resp_v    = 1'b1;
        resp_type = NACK;
        #1;
        check_output("rst_link_v", link.v, 0);
        check_output("rst_yumi", yumi, 0);
        check_output("rst_incr", incr_v, 0);
        check_output("rst_rollback", rollback_v, 0);
        check_output("rst_ack", ack_v, 0);
        check_output("rst_error", error, 0);
        check_output("rst_outstanding", outstanding, 0);
        @(posedge clk);
        model_reset();
    endtask

    task automatic apply_stimulus(input bit rv, input logic [1:0] rt, input bit rdy);
        bit e_rb, e_ack, e_incr, e_v, e_yumi;
        int size_before;
        @(negedge clk);
        reset_i    = 1'b0;
        fifo_v     = (rd < wr);
        fifo_data  = fifo_v ? mem[rd] : width_lp'($urandom);
        link.ready = rdy;
        resp_v     = rv;
        resp_type  = rt;
        #1;
        size_before = q.size();
        e_rb   = !err && ((rv && rt == NACK) || (size_before > 0 && timer == timeout_lp - 1));
        e_ack  = !err && !e_rb && rv && rt == ACK_ALL;
        e_incr = !err && !e_rb && !e_ack && rv && rt == ACK_ONE && size_before > 0;
        e_v    = !err && fifo_v && size_before < window_lp && !e_rb && !e_ack;
        e_yumi = e_v && rdy;

        seen_v = link.v; seen_yumi = yumi; seen_rb = rollback_v; seen_incr = incr_v;
        seen_err = error; seen_data = link.data; seen_seq = link.seq;

        check_output("rollback", rollback_v, e_rb);
        check_output("ack", ack_v, e_ack);
        check_output("incr", incr_v, e_incr);
        check_output("link_v", link.v, e_v);
        check_output("yumi", yumi, e_yumi);
        check_output("outstanding", outstanding, size_before);
        check_output("error", error, err);
        if (e_v) begin
            check_output("link_seq", link.seq, next_seq);
            check_output("link_data", link.data, mem[rd]);
        end

        @(posedge clk);
        if (e_rb) begin
            rd = ckpt;
            if (size_before > 0)
                next_seq = q[0];
            q.delete();
            if (retries == max_retries_lp) err = 1'b1;
            else retries++;
        end else if (e_ack) begin
            ckpt = rd;
            if (size_before > 0) retries = 0;
            q.delete();
        end else begin
            if (e_incr) begin
                ckpt++;
                void'(q.pop_front());
                retries = 0;
            end
            if (e_yumi) begin
                rd++;
                q.push_back(next_seq);
                next_seq = (next_seq + 1) % (1 << seq_width_lp);
            end
        end
        timer = (e_rb || rv || size_before == 0) ? 0 : timer + 1;
    endtask

    initial begin
        int sends, fired;
        logic [width_lp-1:0] d0;
        bit rv;
        int x;
        logic [1:0] rt;

        fifo_v = 1'b0; fifo_data = '0; resp_v = 1'b0; resp_type = '0; link.ready = 1'b0;
        model_reset();

        // Window limit, then incremental retire with a same-cycle send.
        do_reset();
        push_beats(6);
        sends = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, ACK_ONE, 1'b1);
            sends += int'(seen_yumi);
        end
        check_output("window_sends", sends, 4);
        apply_stimulus(1'b1, ACK_ONE, 1'b0);
        apply_stimulus(1'b1, ACK_ONE, 1'b0);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        check_output("retire_seq4", seen_seq, 4);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        check_output("retire_seq5", seen_seq, 5);
        push_beats(2);
        apply_stimulus(1'b1, ACK_ONE, 1'b0);
        apply_stimulus(1'b1, ACK_ONE, 1'b1);
        check_output("ack_with_send", {seen_incr, seen_yumi}, 2'b11);
        apply_stimulus(1'b0, ACK_ONE, 1'b0);

        // Cumulative ack with a beat waiting at the head.
        do_reset();
        push_beats(5);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, ACK_ONE, 1'b1);
        apply_stimulus(1'b1, ACK_ALL, 1'b1);
        check_output("ackall_no_yumi", seen_yumi, 0);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        check_output("ackall_next_seq", seen_seq, 3);
        apply_stimulus(1'b1, ACK_ALL, 1'b0);

        // NACK replays from the oldest unacked beat with its original data.
        do_reset();
        push_beats(5);
        d0 = mem[0];
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, ACK_ONE, 1'b1);
        apply_stimulus(1'b1, NACK, 1'b1);
        check_output("nack_link_v", seen_v, 0);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        check_output("replay_seq", seen_seq, 0);
        check_output("replay_data", seen_data, d0);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);

        // Timeout fires on the 8th idle cycle; a response restarts the count.
        do_reset();
        push_beats(2);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        fired = -1;
        for (int i = 1; i <= 20; i++) begin
            apply_stimulus(1'b0, ACK_ONE, 1'b0);
            if (seen_rb) begin
                fired = i;
                break;
            end
        end
        check_output("timeout_cycle", fired, 8);

        do_reset();
        push_beats(2);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, ACK_ONE, 1'b0);
        apply_stimulus(1'b1, ACK_ONE, 1'b0);
        fired = -1;
        for (int i = 1; i <= 20; i++) begin
            apply_stimulus(1'b0, ACK_ONE, 1'b0);
            if (seen_rb) begin
                fired = i;
                break;
            end
        end
        check_output("timeout_after_resp", fired, 8);

        // Retry exhaustion: the fourth consecutive rollback latches the error.
        do_reset();
        push_beats(4);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, ACK_ONE, 1'b1);
            apply_stimulus(1'b1, NACK, 1'b1);
        end
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1);
        check_output("error_sticky", seen_err, 1);
        do_reset();
        apply_stimulus(1'b0, ACK_ONE, 1'b1);
        check_output("error_cleared", seen_err, 0);

        // Randomized traffic with periodic resets.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                if (wr - rd < 3) push_beats($urandom_range(0, 3));
                rv = ($urandom_range(0, 3) == 0);
                x  = $urandom_range(0, 9);
                rt = (x < 5) ? 2'd0 : (x < 8) ? 2'd1 : (x < 9) ? 2'd2 : 2'd3;
                apply_stimulus(rv, rt, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
